// File: rtl/clk_div_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen_if
// Description : Control/status bundle for the clk_div_gen divider.
//               master : the controller (drives en/div_ratio/load/cnt_clr,
//                        observes clk_out/tick/cycle_count/busy)
//               slave  : the divider itself
//               With CLK_DIV_TERMINAL_EN defined the bundle also carries
//               max_cycles (master -> slave) and done (slave -> master).
// Revision    : 1.0 - initial release
// ============================================================================
interface clk_div_gen_if #(
    parameter int CNT_W = 16,
    parameter int CYC_W = 32
) ();
    logic             en;
    logic [CNT_W-1:0] div_ratio;
    logic             load;
    logic             cnt_clr;
    logic             clk_out;
    logic             tick;
    logic [CYC_W-1:0] cycle_count;
    logic             busy;
`ifdef CLK_DIV_TERMINAL_EN
    logic [CYC_W-1:0] max_cycles;
    logic             done;

    modport master (
        output en, div_ratio, load, cnt_clr, max_cycles,
        input  clk_out, tick, cycle_count, busy, done
    );
    modport slave (
        input  en, div_ratio, load, cnt_clr, max_cycles,
        output clk_out, tick, cycle_count, busy, done
    );
`else
    modport master (
        output en, div_ratio, load, cnt_clr,
        input  clk_out, tick, cycle_count, busy
    );
    modport slave (
        input  en, div_ratio, load, cnt_clr,
        output clk_out, tick, cycle_count, busy
    );
`endif
endinterface
`default_nettype wire

// File: rtl/clk_div_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_gen
// Description : Programmable clock divider / clock-enable generator.
//               Divides clk by a runtime ratio N (values below 2 become 2),
//               producing a registered divided clock, a one-cycle tick at
//               each output period start and a saturating period counter.
//               Stopping is graceful: the running period always completes.
// Ports       : clk  - system clock, all logic on posedge
//               rst  - synchronous reset, active high
//               bus  - clk_div_gen_if.slave:
//                      en, div_ratio, load, cnt_clr            (inputs)
//                      clk_out, tick, cycle_count, busy        (outputs)
// Options     : CLK_DIV_TERMINAL_EN - adds max_cycles input and done output;
//               the run stops by itself once cycle_count hits max_cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_gen #(
    parameter int CNT_W   = 16,
    parameter int CYC_W   = 32,
    parameter int DEF_DIV = 4
) (
    input  wire logic    clk,
    input  wire logic    rst,
    clk_div_gen_if.slave bus
);

    localparam logic [1:0]       c_IDLE    = 2'd0;
    localparam logic [1:0]       c_RUN     = 2'd1;
    localparam logic [1:0]       c_STOP    = 2'd2;
    localparam logic [CNT_W-1:0] c_DIV_MIN = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_DEF_DIV = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);
    localparam logic [CYC_W-1:0] c_CYC_MAX = '1;

    // Registered state
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_ratio;
    logic [CNT_W-1:0] r_shadow;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_busy;
    logic [CYC_W-1:0] r_count;

    // Next-state values
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_ratio_nxt;
    logic [CNT_W-1:0] w_shadow_nxt;
    logic             w_pending_nxt;
    logic             w_clk_out_nxt;
    logic             w_tick_nxt;
    logic             w_busy_nxt;
    logic [CYC_W-1:0] w_count_nxt;

    logic [CNT_W-1:0] w_load_val;
    logic             w_last;
    logic [CNT_W:0]   w_high;
    logic             w_go;
    logic             w_run;

    // Clamp happens on the way into the ratio registers, so the counter
    // never sees N < 2.
    assign w_load_val = (bus.div_ratio < c_DIV_MIN) ? c_DIV_MIN : bus.div_ratio;
    assign w_last     = (r_cnt == (r_ratio - c_ONE));

    // High time is computed from the ratio that governs the next cycle, so a
    // ratio switched in at a boundary shapes its first period correctly.
    assign w_high = ({1'b0, w_ratio_nxt} + {{CNT_W{1'b0}}, 1'b1}) >> 1;

`ifdef CLK_DIV_TERMINAL_EN
    logic r_done;
    logic r_en_d;
    logic w_done_nxt;
    logic w_hit;

    assign w_hit = (bus.max_cycles != '0) && (r_count == bus.max_cycles);
    // After a limit stop, only a fresh 0->1 of en may start a new run.
    assign w_go  = bus.en && !(r_done && r_en_d);
    assign w_run = bus.en && !w_hit;
    assign bus.done = r_done;
`else
    assign w_go  = bus.en;
    assign w_run = bus.en;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_ratio   <= c_DEF_DIV;
            r_shadow  <= c_DEF_DIV;
            r_pending <= 1'b0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
            r_busy    <= 1'b0;
            r_count   <= '0;
`ifdef CLK_DIV_TERMINAL_EN
            r_done    <= 1'b0;
            r_en_d    <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ratio   <= w_ratio_nxt;
            r_shadow  <= w_shadow_nxt;
            r_pending <= w_pending_nxt;
            r_clk_out <= w_clk_out_nxt;
            r_tick    <= w_tick_nxt;
            r_busy    <= w_busy_nxt;
            r_count   <= w_count_nxt;
`ifdef CLK_DIV_TERMINAL_EN
            r_done    <= w_done_nxt;
            r_en_d    <= bus.en;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, period counter, ratio shadowing
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_ratio_nxt   = r_ratio;
        w_shadow_nxt  = r_shadow;
        w_pending_nxt = r_pending;

        case (r_state)
            c_IDLE: begin
                w_cnt_nxt = '0;
                if (w_go) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN, c_STOP: begin
                if (w_last) begin
                    w_cnt_nxt = '0;
                    // STOP always finishes into IDLE, even if en came back
                    // on the final cycle of the period.
                    w_state_nxt = ((r_state == c_RUN) && w_run) ? c_RUN : c_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt + c_ONE;
                    w_state_nxt = w_run ? c_RUN : c_STOP;
                end
            end
            default: begin
                w_state_nxt = c_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        if (r_state == c_IDLE) begin
            if (bus.load) begin
                w_shadow_nxt  = w_load_val;
                w_ratio_nxt   = w_load_val;
                w_pending_nxt = 1'b0;
            end
        end else begin
            if (bus.load) begin
                w_shadow_nxt  = w_load_val;
                w_pending_nxt = 1'b1;
            end
            // A load landing on the boundary cycle itself is the newest
            // value, so it takes effect directly.
            if (w_last) begin
                if (bus.load) begin
                    w_ratio_nxt = w_load_val;
                end else if (r_pending) begin
                    w_ratio_nxt = r_shadow;
                end
                w_pending_nxt = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic (values registered alongside the counter)
    // ------------------------------------------------------------------
    always_comb begin
        w_busy_nxt    = (w_state_nxt != c_IDLE);
        w_clk_out_nxt = (w_state_nxt != c_IDLE) && ({1'b0, w_cnt_nxt} < w_high);
        // A period starts either on leaving IDLE or on a RUN wrap.
        w_tick_nxt    = (w_state_nxt == c_RUN) && ((r_state == c_IDLE) || w_last);

        if (bus.cnt_clr) begin
            // Clear and a coincident period start: keep the new edge.
            w_count_nxt = w_tick_nxt ? CYC_W'(1) : '0;
        end else if (w_tick_nxt && (r_count != c_CYC_MAX)) begin
            w_count_nxt = r_count + CYC_W'(1);
        end else begin
            w_count_nxt = r_count;
        end

`ifdef CLK_DIV_TERMINAL_EN
        if ((r_state == c_IDLE) && w_go) begin
            w_done_nxt = 1'b0;
        end else if ((r_state != c_IDLE) && (w_state_nxt == c_IDLE) && w_hit) begin
            w_done_nxt = 1'b1;
        end else begin
            w_done_nxt = r_done;
        end
`endif
    end

    assign bus.clk_out     = r_clk_out;
    assign bus.tick        = r_tick;
    assign bus.busy        = r_busy;
    assign bus.cycle_count = r_count;

endmodule
`default_nettype wire
